// File: rtl/mult_controller.sv
// mult_controller: control FSM for a shift-free repeated-addition multiplier.
// Loads operand A then operand B from a valid-qualified bus, clears the
// product, then adds A into P while decrementing B until B reaches zero.
// An iteration limit aborts runaway operations with a sticky error flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request a new multiplication (ignored while busy)
//   data_valid / data_ready  operand word handshake (LOAD_A, LOAD_B)
//   eqz                      datapath B register is zero
//   ld_a, ld_b, ld_p,
//   clr_p, dec_b             datapath register controls
//   busy                     not in IDLE
//   done                     one-cycle completion pulse (also on error)
//   err                      iteration limit hit; sticky until next start/rst
//   iter_cnt                 add iterations in current/last operation
module mult_controller #(
   parameter int ITER_W   = 15,
   parameter int MAX_ITER = 32767
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              eqz,
   output logic              ld_a,
   output logic              ld_b,
   output logic              ld_p,
   output logic              clr_p,
   output logic              dec_b,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, CLR_P, CHECK, ADD, DONE, ERR
   } state_t;

   localparam logic [ITER_W-1:0] MAX_C = ITER_W'(MAX_ITER);

   state_t            state_q, state_d;
   logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
   logic              err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         iter_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_cnt_q <= iter_cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      iter_cnt_d = iter_cnt_q;
      err_d      = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LOAD_A;
               iter_cnt_d = '0;
               err_d      = 1'b0;
            end
         end
         LOAD_A: if (data_valid) state_d = LOAD_B;
         LOAD_B: if (data_valid) state_d = CLR_P;
         CLR_P:  state_d = CHECK;
         CHECK: begin
            // zero test wins over the limit so an exact-limit product still completes
            if (eqz) begin
               state_d = DONE;
            end else if (iter_cnt_q == MAX_C) begin
               state_d = ERR;
               err_d   = 1'b1;   // registered now so err and done coincide in ERR
            end else begin
               state_d = ADD;
            end
         end
         ADD: begin
            state_d = CHECK;
            // saturate rather than wrap if MAX_ITER is set to the counter's full range
            if (iter_cnt_q != '1) iter_cnt_d = iter_cnt_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs except the load strobes, which are qualified by data_valid
   always_comb begin
      data_ready = 1'b0;
      ld_a       = 1'b0;
      ld_b       = 1'b0;
      ld_p       = 1'b0;
      clr_p      = 1'b0;
      dec_b      = 1'b0;
      done       = 1'b0;
      busy       = (state_q != IDLE);
      unique case (state_q)
         LOAD_A: begin
            data_ready = 1'b1;
            ld_a       = data_valid;
         end
         LOAD_B: begin
            data_ready = 1'b1;
            ld_b       = data_valid;
         end
         CLR_P: clr_p = 1'b1;
         ADD: begin
            ld_p  = 1'b1;
            dec_b = 1'b1;
         end
         DONE:    done = 1'b1;
         ERR:     done = 1'b1;
         default: ;
      endcase
   end

   assign err      = err_q;
   assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: table of operations checked through a scoreboard
// plus hand sequences for busy-start, mid-operation reset and the iteration limit.
module tb_mult_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, data_valid, eqz;
   logic        data_ready, ld_a, ld_b, ld_p, clr_p, dec_b, busy, done, err;
   logic [14:0] iter_cnt;
   logic [7:0]  bus, breg;

   // second instance with a tiny limit and eqz stuck low
   logic        start2, dv2;
   logic        data_ready2, ld_a2, ld_b2, ld_p2, clr_p2, dec_b2, busy2, done2, err2;
   logic [14:0] iter_cnt2;

   mult_controller u_dut (
      .clk(clk), .rst(rst), .start(start), .data_valid(data_valid),
      .data_ready(data_ready), .eqz(eqz), .ld_a(ld_a), .ld_b(ld_b),
      .ld_p(ld_p), .clr_p(clr_p), .dec_b(dec_b), .busy(busy), .done(done),
      .err(err), .iter_cnt(iter_cnt));

   mult_controller #(.ITER_W(15), .MAX_ITER(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .data_valid(dv2),
      .data_ready(data_ready2), .eqz(1'b0), .ld_a(ld_a2), .ld_b(ld_b2),
      .ld_p(ld_p2), .clr_p(clr_p2), .dec_b(dec_b2), .busy(busy2), .done(done2),
      .err(err2), .iter_cnt(iter_cnt2));

   // datapath B register model feeding eqz
   initial forever begin
      @(posedge clk);
      if (ld_b) breg <= bus;
      else if (dec_b) breg <= breg - 8'd1;
   end
   assign eqz = (breg == 8'd0);

   int tests = 0;
   int fails = 0;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   typedef struct {int lat; int iter;} exp_t;
   exp_t sb[$];

   typedef struct {int a; int b; int ga; int gb; int lat; int iter;} vec_t;

   // monitor: latency from start, strobe counts, exclusivity, scoreboard pop on done
   int cyc = 0, rise = 0, n_lda = 0, n_ldb = 0, n_ldp = 0;
   bit busy_prev = 1'b0;
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         busy_prev = 1'b0;
      end else begin
         if (busy && !busy_prev) begin
            rise = cyc; n_lda = 0; n_ldb = 0; n_ldp = 0;
         end
         if (ld_a) n_lda++;
         if (ld_b) n_ldb++;
         if (ld_p) n_ldp++;
         if ($countones({ld_a, ld_b, clr_p, ld_p}) > 1 || ld_p != dec_b)
            chk("ctrl_exclusive", 0, 1);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("latency", cyc - rise + 1, e.lat);
               chk("iter_cnt", iter_cnt, e.iter);
               chk("ld_p_count", n_ldp, e.iter);
               chk("ld_a_count", n_lda, 1);
               chk("ld_b_count", n_ldb, 1);
               chk("err_on_done", err, 0);
            end
         end
         busy_prev = busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // called in IDLE at posedge+2; spam re-pulses start while busy
   task automatic run_op(vec_t v, bit spam);
      bit fin = 1'b0;
      sb.push_back('{v.lat, v.iter});
      start = 1'b1;
      tick();
      start = spam;
      for (int i = 0; i < v.ga; i++) begin data_valid = 1'b0; tick(); end
      bus = 8'(v.a); data_valid = 1'b1; tick();
      for (int i = 0; i < v.gb; i++) begin data_valid = 1'b0; tick(); end
      bus = 8'(v.b); data_valid = 1'b1; tick();
      data_valid = 1'b0; bus = 8'd0;
      for (int n = 0; n < 300; n++) begin
         if (!busy) begin fin = 1'b1; break; end
         start = spam & n[0];
         tick();
      end
      start = 1'b0;
      if (!fin) chk("op_timeout", 0, 1);
      chk("iter_hold_idle", iter_cnt, v.iter);
      tick();
      chk("iter_hold_idle2", iter_cnt, v.iter);
   endtask

   initial begin
      vec_t vt[6];
      bit   got;
      int   np, c;
      vt[0] = '{5, 3, 0, 0, 11, 3};
      vt[1] = '{7, 0, 0, 0, 5, 0};
      vt[2] = '{5, 3, 4, 2, 17, 3};
      vt[3] = '{1, 1, 0, 0, 7, 1};
      vt[4] = '{9, 6, 1, 0, 18, 6};
      vt[5] = '{2, 10, 0, 3, 28, 10};

      rst = 1'b1; start = 1'b0; data_valid = 1'b0; bus = 8'd0;
      start2 = 1'b0; dv2 = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {ld_a, ld_b, ld_p, clr_p, dec_b, busy, done, err, data_ready}, 0);
      chk("reset_iter", iter_cnt, 0);
      chk("reset_outputs2", {ld_a2, ld_b2, ld_p2, clr_p2, dec_b2, busy2, done2, err2, data_ready2}, 0);

      // start coinciding with reset is dropped
      start = 1'b1; tick();
      rst = 1'b0; start = 1'b0;
      chk("start_in_reset_busy", busy, 0);
      tick();
      chk("start_in_reset_busy2", busy, 0);

      for (int i = 0; i < 6; i++) run_op(vt[i], 1'b0);

      // start hammered while busy must not disturb the operation
      run_op(vt[0], 1'b1);

      // reset during the second ADD: everything clears, no done
      start = 1'b1; tick();
      start = 1'b0; bus = 8'd5; data_valid = 1'b1; tick();
      bus = 8'd3; tick();
      data_valid = 1'b0; bus = 8'd0;
      repeat (4) tick();
      chk("second_add_ld_p", ld_p, 1);
      rst = 1'b1; start = 1'b1; tick();
      chk("midop_reset_outputs", {ld_a, ld_b, ld_p, clr_p, dec_b, busy, done, err, data_ready}, 0);
      chk("midop_reset_iter", iter_cnt, 0);
      tick();
      rst = 1'b0; start = 1'b0;
      chk("midop_reset_idle", busy, 0);
      tick();
      run_op(vt[0], 1'b0);

      // iteration limit on the MAX_ITER=4 instance
      start2 = 1'b1; tick();
      start2 = 1'b0; dv2 = 1'b1; tick();
      tick();
      dv2 = 1'b0;
      got = 1'b0; np = 0; c = 3;
      for (int k = 0; k < 40; k++) begin
         if (ld_p2) np++;
         if (done2) begin got = 1'b1; break; end
         tick(); c++;
      end
      chk("err_done_seen", got, 1);
      chk("err_latency", c, 13);
      chk("err_with_done", err2, 1);
      chk("err_add_count", np, 4);
      chk("err_iter", iter_cnt2, 4);
      tick();
      chk("err_idle_done", done2, 0);
      chk("err_idle_busy", busy2, 0);
      chk("err_sticky", err2, 1);
      repeat (3) tick();
      chk("err_sticky_later", err2, 1);
      chk("err_iter_hold", iter_cnt2, 4);
      start2 = 1'b1; tick();
      start2 = 1'b0;
      chk("err_cleared_by_start", err2, 0);
      chk("iter_cleared_by_start", iter_cnt2, 0);
      chk("restart_busy", busy2, 1);

      repeat (2) tick();
      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
